// File: rtl/kernel3_gmem_a_m_axi_read_splitter_pkg.sv
// Shared definitions for the gmem_A read-request splitter: FSM encoding and
// compile-time log2 helper used to size shifts and counters.
package kernel3_gmem_a_m_axi_read_splitter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    // Beat counts up to 256 need nine bits.
    localparam int BEAT_W = 9;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/kernel3_gmem_a_m_axi_read_splitter_credit.sv
// Credit counter for the read-data FIFO: consumes a whole burst at once,
// returns one beat per pop and saturates at the FIFO depth.
module kernel3_gmem_a_m_axi_read_splitter_credit
    import kernel3_gmem_a_m_axi_read_splitter_pkg::*;
#(
    parameter int FIFO_DEPTH = 32,
    parameter int CREDIT_W   = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clk_en,
    input  logic                consume,
    input  logic [BEAT_W-1:0]   consume_beats,
    input  logic                give,
    input  logic [BEAT_W-1:0]   need,
    output logic [CREDIT_W-1:0] credit,
    output logic                ge
);

    localparam logic [CREDIT_W:0] FULL = (CREDIT_W + 1)'(FIFO_DEPTH);

    logic [CREDIT_W:0] sum;

    // A burst is only consumed when credit covers it, so the subtraction never wraps.
    always_comb begin
        sum = {1'b0, credit};
        if (give) begin
            sum = sum + (CREDIT_W + 1)'(1);
        end
        if (consume) begin
            sum = sum - (CREDIT_W + 1)'(consume_beats);
        end
        if (sum > FULL) begin
            sum = FULL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credit <= CREDIT_W'(FIFO_DEPTH);
        end else if (clk_en) begin
            credit <= sum[CREDIT_W-1:0];
        end
    end

    assign ge = ({{BEAT_W{1'b0}}, credit} >= {{CREDIT_W{1'b0}}, need});

endmodule

// File: rtl/kernel3_gmem_a_m_axi_read_splitter.sv
// Splits one user read request into AXI AR bursts capped at MAX_BURST beats,
// never crossing a BOUNDARY page, issued only when the R-data FIFO has room.
module kernel3_gmem_a_m_axi_read_splitter
    import kernel3_gmem_a_m_axi_read_splitter_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int LEN_WIDTH  = 32,
    parameter int BUS_BYTES  = 64,
    parameter int MAX_BURST  = 16,
    parameter int BOUNDARY   = 4096,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_en,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    output logic [ADDR_WIDTH-1:0] ar_addr,
    output logic [7:0]            ar_len,
    input  logic                  rdata_pop,
    output logic                  busy
);

    localparam int BYTE_SHIFT = log2_ceil(BUS_BYTES);
    localparam int CREDIT_W   = log2_ceil(FIFO_DEPTH + 1);

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [LEN_WIDTH-1:0]    remain;
    logic [BEAT_W-1:0]       beats;
    logic [BEAT_W-1:0]       beats_calc;
    logic [BEAT_W-1:0]       need;
    logic [LEN_WIDTH-1:0]    calc_len;
    logic [ADDR_WIDTH-1:0]   page_off;
    logic [ADDR_WIDTH-1:0]   page_room;
    logic [CREDIT_W-1:0]     credit;
    logic                    credit_ge;
    logic                    accept;
    logic                    handshake;

    assign accept    = req_valid && (state == IDLE);
    assign handshake = ar_valid && ar_ready;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Burst size: smallest of what is left, the burst cap and the room to the page end.
    always_comb begin
        page_off  = cur_addr & ADDR_WIDTH'(BOUNDARY - 1);
        page_room = (ADDR_WIDTH'(BOUNDARY) - page_off) >> BYTE_SHIFT;
        calc_len  = remain;
        if (calc_len > LEN_WIDTH'(MAX_BURST)) begin
            calc_len = LEN_WIDTH'(MAX_BURST);
        end
        if (LEN_WIDTH'(page_room) < calc_len) begin
            calc_len = LEN_WIDTH'(page_room);
        end
        beats_calc = BEAT_W'(calc_len);
    end

    // In CALC the freshly computed size is checked so ar_valid can rise on entry to ISSUE.
    assign need = (state == CALC) ? beats_calc : beats;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid && (req_len != '0)) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                state_next = ISSUE;
            end
            ISSUE: begin
                if (handshake) begin
                    state_next = (remain == LEN_WIDTH'(beats)) ? IDLE : CALC;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ar_valid <= 1'b0;
            ar_addr  <= '0;
            ar_len   <= '0;
        end else if (clk_en) begin
            if ((state == CALC) && credit_ge) begin
                ar_valid <= 1'b1;
                ar_addr  <= cur_addr;
                ar_len   <= 8'(beats_calc - BEAT_W'(1));
            end else if ((state == ISSUE) && !ar_valid && credit_ge) begin
                ar_valid <= 1'b1;
                ar_addr  <= cur_addr;
                ar_len   <= 8'(beats - BEAT_W'(1));
            end else if (handshake) begin
                ar_valid <= 1'b0;
            end
        end
    end

    // Request bookkeeping carries no reset; it is always loaded before use.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (accept && (req_len != '0)) begin
                cur_addr <= req_addr;
                remain   <= req_len;
            end
            if (state == CALC) begin
                beats <= beats_calc;
            end
            if ((state == ISSUE) && handshake) begin
                cur_addr <= cur_addr + (ADDR_WIDTH'(beats) << BYTE_SHIFT);
                remain   <= remain - LEN_WIDTH'(beats);
            end
        end
    end

    kernel3_gmem_a_m_axi_read_splitter_credit #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CREDIT_W   (CREDIT_W)
    ) u_credit (
        .clk           (clk),
        .reset_n       (reset_n),
        .clk_en        (clk_en),
        .consume       (handshake),
        .consume_beats (beats),
        .give          (rdata_pop),
        .need          (need),
        .credit        (credit),
        .ge            (credit_ge)
    );

endmodule
